// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data accesses, one access in flight
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        flush_f,
   output logic        if_valid,
   output logic [31:0] if_data,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_be,
   output logic        dm_done,
   output logic [31:0] dm_rdata,
   output logic        dm_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   state_t      state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        drop_q, drop_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic        data_win;
   assign data_win = dm_req && (!if_req || starve_cnt_q < LIMIT);
   // next state: arbitrate only from IDLE, then hold the request until the ack retires it
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      drop_d       = drop_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (data_win) begin
               state_d      = DATA;
               mem_req_d    = 1'b1;
               mem_we_d     = dm_we;
               mem_addr_d   = dm_addr;
               mem_wdata_d  = dm_wdata;
               mem_be_d     = dm_be;
               starve_cnt_d = (if_req && starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
            end else if (if_req) begin
               state_d      = FETCH;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = if_addr;
               mem_be_d     = 4'hF;
               starve_cnt_d = '0;
            end
         end
         FETCH: begin
            drop_d = drop_q || flush_f;
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
            end
         end
         DATA: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and registered memory request fields
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         drop_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         drop_q       <= drop_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
      end
   end
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign if_valid  = (state_q == FETCH) && mem_ack && !drop_q && !flush_f;
   assign dm_done   = (state_q == DATA) && mem_ack;
   assign dm_stall  = dm_req && !dm_done;
   assign if_data   = mem_rdata;
   assign dm_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, starvation, flush and latency
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        flush_f = 1'b0;
   logic        if_valid;
   logic [31:0] if_data;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [3:0]  dm_be = '0;
   logic        dm_done;
   logic [31:0] dm_rdata;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_rise = 0;
   int rise_gap = 0;
   logic req_prev = 1'b0;
   logic [31:0] addrs [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush_f(flush_f),
      .if_valid(if_valid), .if_data(if_data), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_done(dm_done),
      .dm_rdata(dm_rdata), .dm_stall(dm_stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // measure the spacing between successive rising edges of mem_req
   always @(negedge clk) begin
      if (mem_req && !req_prev) begin
         rise_gap = cyc - last_rise;
         last_rise = cyc;
      end
      req_prev = mem_req;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   initial begin
      tick;
      tick;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", 32'(mem_be), 0);
      chk("rst_if_valid", 32'(if_valid), 0);
      chk("rst_dm_done", 32'(dm_done), 0);
      chk("rst_dm_stall", 32'(dm_stall), 0);
      rst = 1'b0;
      if_req = 1'b1;
      if_addr = 32'h20;
      tick;
      chk("midrst_req_up", 32'(mem_req), 1);
      rst = 1'b1;
      if_req = 1'b0;
      tick;
      chk("midrst_req_down", 32'(mem_req), 0);
      chk("midrst_addr", mem_addr, 0);
      rst = 1'b0;
      mem_ack = 1'b1;
      #1;
      chk("late_ack_if_valid", 32'(if_valid), 0);
      chk("late_ack_dm_done", 32'(dm_done), 0);
      tick;
      chk("late_ack_idle", 32'(mem_req), 0);
      mem_ack = 1'b0;
      // single fetch, ack two cycles after mem_req
      if_req = 1'b1;
      if_addr = 32'h10;
      tick;
      chk("fetch_req", 32'(mem_req), 1);
      chk("fetch_addr", mem_addr, 32'h10);
      chk("fetch_we", 32'(mem_we), 0);
      chk("fetch_be", 32'(mem_be), 32'hF);
      chk("fetch_wait_valid", 32'(if_valid), 0);
      tick;
      chk("fetch_hold_addr", mem_addr, 32'h10);
      mem_ack = 1'b1;
      mem_rdata = 32'h0050_0093;
      #1;
      chk("fetch_valid", 32'(if_valid), 1);
      chk("fetch_data", if_data, 32'h0050_0093);
      tick;
      mem_ack = 1'b0;
      if_req = 1'b0;
      #1;
      chk("fetch_valid_once", 32'(if_valid), 0);
      chk("fetch_req_clear", 32'(mem_req), 0);
      // store beats a simultaneous fetch
      if_req = 1'b1;
      if_addr = 32'h80;
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_addr = 32'h40;
      dm_wdata = 32'hDEAD_BEEF;
      dm_be = 4'b0011;
      #1;
      chk("st_stall_idle", 32'(dm_stall), 1);
      tick;
      chk("st_req", 32'(mem_req), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", mem_addr, 32'h40);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_be", 32'(mem_be), 32'h3);
      chk("st_stall", 32'(dm_stall), 1);
      tick;
      chk("st_stall_wait", 32'(dm_stall), 1);
      mem_ack = 1'b1;
      #1;
      chk("st_done", 32'(dm_done), 1);
      chk("st_stall_off", 32'(dm_stall), 0);
      chk("st_no_if_valid", 32'(if_valid), 0);
      tick;
      mem_ack = 1'b0;
      dm_req = 1'b0;
      #1;
      chk("st_req_clear", 32'(mem_req), 0);
      tick;
      chk("st_then_fetch_addr", mem_addr, 32'h80);
      chk("st_then_fetch_we", 32'(mem_we), 0);
      chk("st_then_fetch_be", 32'(mem_be), 32'hF);
      mem_ack = 1'b1;
      #1;
      chk("st_then_fetch_valid", 32'(if_valid), 1);
      tick;
      mem_ack = 1'b0;
      if_req = 1'b0;
      // starvation: both held, grant order D D D D F repeating
      if_req = 1'b1;
      if_addr = 32'h200;
      dm_req = 1'b1;
      dm_we = 1'b1;
      dm_addr = 32'h100;
      for (int i = 0; i < 10; i++) begin
         tick;
         chk($sformatf("starve_grant%0d", i), mem_addr, (i % 5 == 4) ? 32'h200 : 32'h100);
         mem_ack = 1'b1;
         #1;
         chk($sformatf("starve_strobe%0d", i), 32'((i % 5 == 4) ? if_valid : dm_done), 1);
         tick;
         mem_ack = 1'b0;
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      dm_we = 1'b0;
      // flush one cycle before the ack
      if_req = 1'b1;
      if_addr = 32'h300;
      tick;
      chk("fl1_addr", mem_addr, 32'h300);
      flush_f = 1'b1;
      if_addr = 32'h340;
      #1;
      chk("fl1_no_valid_a", 32'(if_valid), 0);
      tick;
      flush_f = 1'b0;
      mem_ack = 1'b1;
      #1;
      chk("fl1_no_valid_b", 32'(if_valid), 0);
      tick;
      mem_ack = 1'b0;
      #1;
      chk("fl1_idle", 32'(mem_req), 0);
      tick;
      chk("fl1_reissue", 32'(mem_req), 1);
      chk("fl1_new_addr", mem_addr, 32'h340);
      // flush coincident with the ack
      flush_f = 1'b1;
      mem_ack = 1'b1;
      if_addr = 32'h380;
      #1;
      chk("fl2_no_valid", 32'(if_valid), 0);
      tick;
      flush_f = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("fl2_idle", 32'(mem_req), 0);
      tick;
      chk("fl2_reissue", 32'(mem_req), 1);
      chk("fl2_new_addr", mem_addr, 32'h380);
      mem_ack = 1'b1;
      #1;
      chk("fl2_next_valid", 32'(if_valid), 1);
      tick;
      mem_ack = 1'b0;
      if_req = 1'b0;
      // back-to-back loads with a one-cycle memory
      for (int i = 0; i < 4; i++) begin
         dm_req = 1'b1;
         dm_we = 1'b0;
         dm_addr = addrs[i];
         tick;
         chk($sformatf("ld%0d_req", i), 32'(mem_req), 1);
         chk($sformatf("ld%0d_addr", i), mem_addr, addrs[i]);
         chk($sformatf("ld%0d_we", i), 32'(mem_we), 0);
         mem_ack = 1'b1;
         mem_rdata = rd_of(mem_addr);
         #1;
         chk($sformatf("ld%0d_done", i), 32'(dm_done), 1);
         chk($sformatf("ld%0d_rdata", i), dm_rdata, rd_of(addrs[i]));
         tick;
         mem_ack = 1'b0;
         dm_req = 1'b0;
         if (i > 0) chk($sformatf("ld%0d_gap", i), 32'(rise_gap), 3);
         chk($sformatf("ld%0d_starve", i), 32'(dut.starve_cnt_q), 0);
         tick;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
